// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the byte-serial memory arbiter.
package mem_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_MEM_WR = 2'd3
  } arb_state_t;

  // mem_len encodings; any value with bit 1 set selects a word.
  localparam logic [1:0]  LEN_B     = 2'b00;
  localparam logic [1:0]  LEN_H     = 2'b01;
  localparam logic [1:0]  LEN_W     = 2'b10;
  localparam logic [31:0] ZERO_WORD = '0;

  // Index of the final byte of a MEM transaction of the given length.
  function automatic logic [1:0] last_byte_idx(input logic [1:0] len);
    logic [1:0] idx;
    idx = 2'd3;
    case (len)
      LEN_B:   idx = 2'd0;
      LEN_H:   idx = 2'd1;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Extract byte idx of a little-endian word.
  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

  // Replace byte idx of a little-endian word.
  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    w[{idx, 3'b000} +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one RAM port between instruction fetch and data access.
// Non-preemptive; MEM wins when both request in IDLE. Reads assemble bytes
// little-endian into a shared buffer, which also holds store data for writes.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IF_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              if_busy,
  output logic              mem_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  localparam logic [1:0] IF_LAST = 2'(IF_LEN - 1);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        last_q;
  logic [1:0]        cnt_q;
  logic [31:0]       buf_q;
  logic [31:0]       rd_word;
  logic              if_done_q, mem_done_q;
  logic [31:0]       if_data_q, mem_rdata_q;
  logic              grant_mem, grant_if;
  logic              byte_act, rd_act;
  logic              finish, abort;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Grant decision and per-byte sequencing. A requester whose done pulse is
  // still visible keeps req high that cycle, so it is excluded from the grant.
  always_comb begin
    state_d   = state_q;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    byte_act  = 1'b0;
    rd_act    = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req && !mem_done_q) begin
          grant_mem = 1'b1;
          state_d   = mem_we ? ST_MEM_WR : ST_MEM_RD;
        end else if (if_req && !if_done_q && !flush) begin
          grant_if = 1'b1;
          state_d  = ST_IF_RD;
        end
      end
      ST_IF_RD: begin
        byte_act = 1'b1;
        rd_act   = 1'b1;
        // flush outranks completion, even on the final byte
        if (flush) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == last_q) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_MEM_RD: begin
        byte_act = 1'b1;
        rd_act   = 1'b1;
        if (cnt_q == last_q) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_MEM_WR: begin
        byte_act = 1'b1;
        if (cnt_q == last_q) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Buffer with the current RAM byte merged in at the active position.
  assign rd_word = put_byte(buf_q, cnt_q, ram_dout);

  // RAM port: driven only during active byte cycles, zero otherwise.
  always_comb begin
    ram_addr = '0;
    ram_wr   = 1'b0;
    ram_din  = '0;
    if (byte_act) ram_addr = base_q + ADDR_W'(cnt_q);
    if (state_q == ST_MEM_WR) begin
      ram_wr  = 1'b1;
      ram_din = get_byte(buf_q, cnt_q);
    end
  end

  // Transaction datapath: latch request at grant, then step byte counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      last_q <= '0;
      cnt_q  <= '0;
      buf_q  <= ZERO_WORD;
    end else if (grant_mem) begin
      base_q <= mem_addr;
      last_q <= last_byte_idx(mem_len);
      cnt_q  <= '0;
      buf_q  <= mem_we ? mem_wdata : ZERO_WORD;
    end else if (grant_if) begin
      base_q <= if_addr;
      last_q <= IF_LAST;
      cnt_q  <= '0;
      buf_q  <= ZERO_WORD;
    end else if (finish || abort) begin
      cnt_q <= '0;
      buf_q <= ZERO_WORD;
    end else if (byte_act) begin
      cnt_q <= cnt_q + 2'd1;
      if (rd_act) buf_q <= rd_word;
    end
  end

  // Completion: one-cycle done pulses and held result words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= ZERO_WORD;
      mem_rdata_q <= ZERO_WORD;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if (finish) begin
        case (state_q)
          ST_IF_RD: begin
            if_done_q <= 1'b1;
            if_data_q <= rd_word;
          end
          ST_MEM_RD: begin
            mem_done_q  <= 1'b1;
            mem_rdata_q <= rd_word;
          end
          ST_MEM_WR: mem_done_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;
  assign if_busy   = if_req & ~if_done_q;
  assign mem_busy  = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of MEM transactions plus hand-written
// sequences for fetch, priority, flush and reset corner cases.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        if_busy;
  logic        mem_busy;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  int n_tests = 0;
  int n_fail  = 0;
  int n_if_done  = 0;
  int n_mem_done = 0;

  mem_arbiter #(.ADDR_W(32), .IF_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .if_busy(if_busy), .mem_busy(mem_busy),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-only RAM contents, combinational read.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    logic [7:0] d;
    case (a)
      32'h0000_0100: d = 8'h13;
      32'h0000_0101: d = 8'h05;
      32'h0000_0102: d = 8'h10;
      32'h0000_0103: d = 8'h00;
      32'h0000_0200: d = 8'h93;
      32'h0000_2000: d = 8'h11;
      32'h0000_2001: d = 8'h22;
      32'h0000_2002: d = 8'h33;
      32'h0000_2003: d = 8'h44;
      32'h0000_0500: d = 8'hEF;
      32'h0000_0501: d = 8'hBE;
      32'h0000_0502: d = 8'hAD;
      32'h0000_0503: d = 8'hDE;
      32'hFFFF_FFFF: d = 8'hAB;
      32'h0000_0000: d = 8'hCD;
      default:       d = 8'h00;
    endcase
    return d;
  endfunction

  assign ram_dout = ram_byte(ram_addr);

  // Count done pulses seen on each clock edge.
  always @(posedge clk) begin
    if (if_done)  n_if_done  <= n_if_done + 1;
    if (mem_done) n_mem_done <= n_mem_done + 1;
  end

  typedef struct {
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned nbytes;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_bus(input string name, input logic [31:0] a, input logic w,
                            input logic [7:0] d);
    check(name, {23'd0, ram_addr, ram_wr, ram_din}, {23'd0, a, w, d});
  endtask

  // Run one MEM transaction starting from IDLE at a negedge.
  task automatic run_mem(input vec_t v, input string tag);
    logic [31:0] a;
    logic [31:0] wd;
    mem_req = 1'b1; mem_we = v.we; mem_len = v.len;
    mem_addr = v.addr; mem_wdata = v.wdata;
    for (int unsigned k = 0; k < v.nbytes; k++) begin
      @(negedge clk);
      a  = v.addr + 32'(k);
      wd = v.wdata >> (8 * k);
      expect_bus({tag, " byte"}, a, v.we, v.we ? wd[7:0] : 8'h00);
      check({tag, " busy"}, {62'd0, mem_done, mem_busy}, 64'd1);
    end
    @(negedge clk);
    check({tag, " done"}, {31'd0, mem_done, mem_busy, mem_rdata}, {31'd0, 2'b10, v.exp_rdata});
    expect_bus({tag, " idle at done"}, 32'h0, 1'b0, 8'h00);
    mem_req = 1'b0;
    @(negedge clk);
    check({tag, " done drop"}, {63'd0, mem_done}, 64'd0);
  endtask

  // Run one 4-byte fetch; request goes (or stays) high at the current negedge.
  task automatic run_fetch(input logic [31:0] a, input logic [31:0] exp, input string tag);
    if_req = 1'b1; if_addr = a;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      expect_bus({tag, " byte"}, a + 32'(k), 1'b0, 8'h00);
      check({tag, " busy"}, {62'd0, if_done, if_busy}, 64'd1);
    end
    @(negedge clk);
    check({tag, " done"}, {31'd0, if_done, if_busy, if_data}, {31'd0, 2'b10, exp});
    if_req = 1'b0;
    @(negedge clk);
    check({tag, " done drop"}, {63'd0, if_done}, 64'd0);
  endtask

  int before_if;
  int before_mem;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = '0; mem_wdata = '0;

    vecs[0] = '{1'b0, 2'b10, 32'h0000_2000, 32'h0,         4, 32'h4433_2211};
    vecs[1] = '{1'b0, 2'b01, 32'h0000_2001, 32'h0,         2, 32'h0000_3322};
    vecs[2] = '{1'b1, 2'b00, 32'h0003_0004, 32'h1234_5678, 1, 32'h0000_3322};
    vecs[3] = '{1'b0, 2'b00, 32'h0000_2003, 32'h0,         1, 32'h0000_0044};
    vecs[4] = '{1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0,         2, 32'h0000_CDAB};
    vecs[5] = '{1'b1, 2'b01, 32'h0000_0040, 32'hA1B2_C3D4, 2, 32'h0000_CDAB};
    vecs[6] = '{1'b0, 2'b10, 32'h0000_0500, 32'h0,         4, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 2'b10, 32'hFFFF_FFFE, 32'h0102_0304, 4, 32'hDEAD_BEEF};
    vecs[8] = '{1'b0, 2'b11, 32'h0000_2000, 32'h0,         4, 32'h4433_2211};

    // Reset values
    repeat (2) @(negedge clk);
    expect_bus("reset bus", 32'h0, 1'b0, 8'h00);
    check("reset done/data", {if_done, mem_done, if_data, mem_rdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    expect_bus("idle bus", 32'h0, 1'b0, 8'h00);

    // Plain fetch at 0x100
    run_fetch(32'h100, 32'h0010_0513, "fetch100");

    // Simultaneous requests: MEM first, IF right after
    if_req = 1'b1; if_addr = 32'h200;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'h2000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      expect_bus("prio mem byte", 32'h2000 + 32'(k), 1'b0, 8'h00);
      check("prio if waits", {62'd0, if_busy, if_done}, 64'd2);
    end
    @(negedge clk);
    check("prio mem done", {31'd0, mem_done, if_done, mem_rdata}, {31'd0, 2'b10, 32'h4433_2211});
    expect_bus("prio idle", 32'h0, 1'b0, 8'h00);
    mem_req = 1'b0;
    run_fetch(32'h200, 32'h0000_0093, "prio fetch");
    check("prio rdata hold", {32'd0, mem_rdata}, {32'd0, 32'h4433_2211});

    // Table of MEM transactions
    for (int i = 0; i < 9; i++) run_mem(vecs[i], $sformatf("vec%0d", i));

    // Requester still holding req during its done cycle is not re-granted
    before_mem = n_mem_done;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h2003;
    @(negedge clk);
    expect_bus("hold byte", 32'h2003, 1'b0, 8'h00);
    @(negedge clk);
    check("hold done", {31'd0, mem_done, mem_rdata}, {31'd0, 1'b1, 32'h44});
    @(negedge clk);
    expect_bus("hold no regrant", 32'h0, 1'b0, 8'h00);
    mem_req = 1'b0;
    @(negedge clk);
    check("hold one pulse", 64'(n_mem_done - before_mem), 64'd1);

    // Flush during fetch byte 2 with a MEM request pending
    before_if = n_if_done;
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    expect_bus("flush byte0", 32'h100, 1'b0, 8'h00);
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h2003;
    @(negedge clk);
    expect_bus("flush nonpreempt", 32'h101, 1'b0, 8'h00);
    @(negedge clk);
    expect_bus("flush byte2", 32'h102, 1'b0, 8'h00);
    flush = 1'b1;
    @(negedge clk);
    expect_bus("flush idle", 32'h0, 1'b0, 8'h00);
    check("flush no done", {63'd0, if_done}, 64'd0);
    flush = 1'b0; if_req = 1'b0;
    @(negedge clk);
    expect_bus("flush mem grant", 32'h2003, 1'b0, 8'h00);
    @(negedge clk);
    check("flush mem done", {31'd0, mem_done, mem_rdata}, {31'd0, 1'b1, 32'h44});
    mem_req = 1'b0;
    @(negedge clk);

    // Flush on the completion edge, then flush in IDLE blocks the IF grant
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 4; k++) @(negedge clk);
    expect_bus("lastflush byte3", 32'h103, 1'b0, 8'h00);
    flush = 1'b1;
    @(negedge clk);
    check("lastflush no done", {31'd0, if_done, if_data}, {31'd0, 1'b0, 32'h0000_0093});
    @(negedge clk);
    expect_bus("idle flush blocks", 32'h0, 1'b0, 8'h00);
    check("lastflush count", 64'(n_if_done - before_if), 64'd0);
    flush = 1'b0;
    run_fetch(32'h100, 32'h0010_0513, "refetch");

    // Async reset in the middle of a word store
    before_mem = n_mem_done;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h600; mem_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    expect_bus("rststore b0", 32'h600, 1'b1, 8'h0D);
    @(negedge clk);
    expect_bus("rststore b1", 32'h601, 1'b1, 8'hF0);
    @(negedge clk);
    expect_bus("rststore b2", 32'h602, 1'b1, 8'hFE);
    #2 rst = 1'b1;
    #1;
    expect_bus("rst async bus", 32'h0, 1'b0, 8'h00);
    check("rst async out", {mem_done, if_done, if_data, mem_rdata}, 64'd0);
    mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    expect_bus("post rst idle", 32'h0, 1'b0, 8'h00);
    check("post rst no done", 64'(n_mem_done - before_mem), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
